// File: rtl/id_pkg.sv
// Shared decode definitions for the instruction-decode stage: field widths,
// opcode/funct encodings, ALU-op bit positions, decode record and reset values.
package id_pkg;

  localparam int INST_W       = 32;
  localparam int DATA_W       = 32;
  localparam int REG_AW       = 5;
  localparam int IMM_W        = 16;
  localparam int SHAMT_W      = 5;
  localparam int ALUOP_W_DFLT = 16;
  localparam int ALU_USED     = 12;  // bits above this stay zero

  // primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_SLTI    = 6'b001010;
  localparam logic [5:0] OP_SLTIU   = 6'b001011;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;

  // SPECIAL funct codes
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  // bit positions inside the one-hot ALU-op bus
  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_NOR  = 4'd3;
  localparam logic [3:0] ALU_ADDU = 4'd4;
  localparam logic [3:0] ALU_SUBU = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  // how the 16-bit immediate becomes a 32-bit operand
  typedef enum logic [1:0] {
    EXT_NONE,
    EXT_ZERO,
    EXT_SIGN,
    EXT_UPPER
  } ext_sel_e;

  // decode record; ALU op kept as an index so its bus width stays a top parameter
  typedef struct packed {
    logic              rd1;
    logic              rd2;
    logic [REG_AW-1:0] wd;
    logic              wreg;
    logic              shamt_op;  // operand 1 is the shift amount
    ext_sel_e          ext;       // operand 2 immediate form
    logic              alu_vld;
    logic [3:0]        alu_idx;
  } dec_t;

  localparam dec_t              RST_DEC  = '0;
  localparam logic [DATA_W-1:0] RST_DATA = '0;
  localparam logic [REG_AW-1:0] RST_ADDR = '0;

  // three-register ALU form: both sources read, result to rd
  function automatic dec_t dec_rtype(input logic [3:0] idx, input logic [REG_AW-1:0] rd);
    dec_t d;
    d         = RST_DEC;
    d.rd1     = 1'b1;
    d.rd2     = 1'b1;
    d.wd      = rd;
    d.wreg    = 1'b1;
    d.alu_vld = 1'b1;
    d.alu_idx = idx;
    return d;
  endfunction

  // register/immediate form: rs read, immediate as operand 2, result to rt
  function automatic dec_t dec_itype(input logic [3:0] idx, input ext_sel_e ext,
                                     input logic [REG_AW-1:0] rt);
    dec_t d;
    d         = RST_DEC;
    d.rd1     = 1'b1;
    d.wd      = rt;
    d.wreg    = 1'b1;
    d.ext     = ext;
    d.alu_vld = 1'b1;
    d.alu_idx = idx;
    return d;
  endfunction

endpackage

// File: rtl/id_imm_ext.sv
// Immediate extender: zero-, sign- or upper-half placement of a 16-bit field.
module id_imm_ext
  import id_pkg::*;
(
  input  logic [IMM_W-1:0]  imm,
  input  ext_sel_e          sel,
  output logic [DATA_W-1:0] ext
);

  // select extension form; EXT_NONE yields zero so unused operands stay clean
  always_comb begin
    ext = '0;
    case (sel)
      EXT_ZERO:  ext = {{(DATA_W-IMM_W){1'b0}}, imm};
      EXT_SIGN:  ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
      EXT_UPPER: ext = {imm, {(DATA_W-IMM_W){1'b0}}};
      default:   ext = '0;
    endcase
  end

endmodule

// File: rtl/id.sv
// Instruction decode stage. Read addresses/enables are combinational from
// inst_i; ALU op, operands and destination are registered one cycle later.
// Optional: define ID_SHIFT_INST_EN to decode SLL/SRL/SRA; otherwise those
// funct codes (including the all-zero word) decode as invalid.
module id
  import id_pkg::*;
#(
  parameter int ALUOP_W = ALUOP_W_DFLT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INST_W-1:0]  inst_i,
  input  logic [DATA_W-1:0]  reg1_data_i,
  input  logic [DATA_W-1:0]  reg2_data_i,
  output logic [REG_AW-1:0]  reg1_addr_o,
  output logic [REG_AW-1:0]  reg2_addr_o,
  output logic               reg1_read_o,
  output logic               reg2_read_o,
  output logic [ALUOP_W-1:0] aluop_o,
  output logic [DATA_W-1:0]  reg1_o,
  output logic [DATA_W-1:0]  reg2_o,
  output logic [REG_AW-1:0]  wd_o,
  output logic               wreg_o
);

  logic [5:0]         op, funct;
  logic [REG_AW-1:0]  rs, rt, rd;
  logic [SHAMT_W-1:0] shamt;
  logic [IMM_W-1:0]   imm;

  assign op    = inst_i[31:26];
  assign rs    = inst_i[25:21];
  assign rt    = inst_i[20:16];
  assign rd    = inst_i[15:11];
  assign shamt = inst_i[10:6];
  assign funct = inst_i[5:0];
  assign imm   = inst_i[15:0];

  dec_t               dec;
  logic [ALUOP_W-1:0] aluop;
  logic [DATA_W-1:0]  imm1, imm2;
  logic [DATA_W-1:0]  opnd1, opnd2;

  // opcode/funct decode; anything unrecognised leaves the all-zero record
  always_comb begin
    dec = RST_DEC;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          FN_AND:  dec = dec_rtype(ALU_AND,  rd);
          FN_OR:   dec = dec_rtype(ALU_OR,   rd);
          FN_XOR:  dec = dec_rtype(ALU_XOR,  rd);
          FN_NOR:  dec = dec_rtype(ALU_NOR,  rd);
          FN_ADDU: dec = dec_rtype(ALU_ADDU, rd);
          FN_SUBU: dec = dec_rtype(ALU_SUBU, rd);
          FN_SLT:  dec = dec_rtype(ALU_SLT,  rd);
          FN_SLTU: dec = dec_rtype(ALU_SLTU, rd);
`ifdef ID_SHIFT_INST_EN
          FN_SLL, FN_SRL, FN_SRA: begin
            // rt is shifted by shamt; rs is not an operand
            dec          = dec_rtype(ALU_SLL, rd);
            dec.rd1      = 1'b0;
            dec.shamt_op = 1'b1;
            if (funct == FN_SRL) dec.alu_idx = ALU_SRL;
            if (funct == FN_SRA) dec.alu_idx = ALU_SRA;
          end
`endif
          default: dec = RST_DEC;
        endcase
      end
      OP_ANDI:  dec = dec_itype(ALU_AND,  EXT_ZERO, rt);
      OP_ORI:   dec = dec_itype(ALU_OR,   EXT_ZERO, rt);
      OP_XORI:  dec = dec_itype(ALU_XOR,  EXT_ZERO, rt);
      OP_ADDIU: dec = dec_itype(ALU_ADDU, EXT_SIGN, rt);
      OP_SLTI:  dec = dec_itype(ALU_SLT,  EXT_SIGN, rt);
      OP_SLTIU: dec = dec_itype(ALU_SLTU, EXT_SIGN, rt);
      OP_LUI: begin
        // no register source: operand 1 is zero, operand 2 the upper immediate
        dec     = dec_itype(ALU_LUI, EXT_UPPER, rt);
        dec.rd1 = 1'b0;
      end
      default: dec = RST_DEC;
    endcase
  end

  // expand ALU index to the one-hot bus
  always_comb begin
    aluop = '0;
    if (dec.alu_vld) aluop[dec.alu_idx] = 1'b1;
  end

  id_imm_ext u_imm_ext (
    .imm (imm),
    .sel (dec.ext),
    .ext (imm2)
  );

  assign imm1 = dec.shamt_op ? {{(DATA_W-SHAMT_W){1'b0}}, shamt} : RST_DATA;

  // operand select: register data when read, else decoded immediate
  always_comb begin
    opnd1 = dec.rd1 ? reg1_data_i : imm1;
    opnd2 = dec.rd2 ? reg2_data_i : imm2;
  end

  // read port drive; reset forces the combinational side quiet too
  always_comb begin
    reg1_addr_o = rst ? RST_ADDR : rs;
    reg2_addr_o = rst ? RST_ADDR : rt;
    reg1_read_o = rst ? 1'b0 : dec.rd1;
    reg2_read_o = rst ? 1'b0 : dec.rd2;
  end

  // ID/EX register; async reset drops whatever decode is in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aluop_o <= '0;
      reg1_o  <= RST_DATA;
      reg2_o  <= RST_DATA;
      wd_o    <= RST_ADDR;
      wreg_o  <= 1'b0;
    end else begin
      aluop_o <= aluop;
      reg1_o  <= opnd1;
      reg2_o  <= opnd2;
      wd_o    <= dec.wd;
      wreg_o  <= dec.wreg;
    end
  end

endmodule

// File: tb/tb_id.sv
// Directed-vector bench for the decode stage, plus reset corner sequences.
module tb_id;

  logic        clk, rst;
  logic [31:0] inst_i, reg1_data_i, reg2_data_i;
  logic [4:0]  reg1_addr_o, reg2_addr_o, wd_o;
  logic        reg1_read_o, reg2_read_o, wreg_o;
  logic [15:0] aluop_o;
  logic [31:0] reg1_o, reg2_o;

  id #(.ALUOP_W(16)) dut (
    .clk(clk), .rst(rst), .inst_i(inst_i),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .aluop_o(aluop_o), .reg1_o(reg1_o), .reg2_o(reg2_o),
    .wd_o(wd_o), .wreg_o(wreg_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] inst, d1, d2;
    logic [4:0]  a1, a2;
    logic        rd1, rd2;
    logic [15:0] aluop;
    logic [31:0] r1, r2;
    logic [4:0]  wd;
    logic        wreg;
  } vec_t;

  vec_t vecs[$];
  int   passed = 0;
  int   total  = 0;

  localparam logic [31:0] D1 = 32'h12345678;
  localparam logic [31:0] D2 = 32'h87654321;

  function automatic vec_t mk(string name, logic [31:0] inst, logic [31:0] d1, logic [31:0] d2,
                              logic [4:0] a1, logic [4:0] a2, logic rd1, logic rd2,
                              logic [15:0] aluop, logic [31:0] r1, logic [31:0] r2,
                              logic [4:0] wd, logic wreg);
    vec_t v;
    v.name = name; v.inst = inst; v.d1 = d1; v.d2 = d2;
    v.a1 = a1; v.a2 = a2; v.rd1 = rd1; v.rd2 = rd2;
    v.aluop = aluop; v.r1 = r1; v.r2 = r2; v.wd = wd; v.wreg = wreg;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic chk_comb(input string name, input logic [4:0] a1, input logic [4:0] a2,
                          input logic rd1, input logic rd2);
    chk({name, "/comb"}, {116'd0, reg1_addr_o, reg2_addr_o, reg1_read_o, reg2_read_o},
        {116'd0, a1, a2, rd1, rd2});
  endtask

  task automatic chk_regs(input string name, input logic [15:0] aluop, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [4:0] wd, input logic wreg);
    chk({name, "/regs"}, {42'd0, aluop_o, reg1_o, reg2_o, wd_o, wreg_o},
        {42'd0, aluop, r1, r2, wd, wreg});
  endtask

  initial begin
    vecs.push_back(mk("ori",   32'h34011100, D1, D2, 5'd0, 5'd1, 1, 0, 16'h0002, D1, 32'h00001100, 5'd1, 1));
    vecs.push_back(mk("addiu", 32'h2422FFFF, D1, D2, 5'd1, 5'd2, 1, 0, 16'h0010, D1, 32'hFFFFFFFF, 5'd2, 1));
    vecs.push_back(mk("or",    32'h00221825, D1, D2, 5'd1, 5'd2, 1, 1, 16'h0002, D1, D2, 5'd3, 1));
    vecs.push_back(mk("and",   32'h00221824, D1, D2, 5'd1, 5'd2, 1, 1, 16'h0001, D1, D2, 5'd3, 1));
    vecs.push_back(mk("nor",   32'h00221827, D1, D2, 5'd1, 5'd2, 1, 1, 16'h0008, D1, D2, 5'd3, 1));
    vecs.push_back(mk("slt",   32'h0022182A, D1, D2, 5'd1, 5'd2, 1, 1, 16'h0040, D1, D2, 5'd3, 1));
    vecs.push_back(mk("subu_shamt", 32'h014B4963, 32'hDEADBEEF, 32'h0BADF00D,
                      5'd10, 5'd11, 1, 1, 16'h0020, 32'hDEADBEEF, 32'h0BADF00D, 5'd9, 1));
    vecs.push_back(mk("bad_funct", 32'h00221801, D1, D2, 5'd1, 5'd2, 0, 0, 16'h0000, 32'h0, 32'h0, 5'd0, 0));
    vecs.push_back(mk("andi_zext", 32'h30628001, D1, D2, 5'd3, 5'd2, 1, 0, 16'h0001, D1, 32'h00008001, 5'd2, 1));
    vecs.push_back(mk("slti_sext", 32'h28868000, D1, D2, 5'd4, 5'd6, 1, 0, 16'h0040, D1, 32'hFFFF8000, 5'd6, 1));
    vecs.push_back(mk("sltiu",     32'h2C077FFF, D1, D2, 5'd0, 5'd7, 1, 0, 16'h0080, D1, 32'h00007FFF, 5'd7, 1));
    vecs.push_back(mk("xori",      32'h3828FFFF, D1, D2, 5'd1, 5'd8, 1, 0, 16'h0004, D1, 32'h0000FFFF, 5'd8, 1));
`ifdef ID_SHIFT_INST_EN
    vecs.push_back(mk("sll", 32'h00022200, D1, D2, 5'd0, 5'd2, 0, 1, 16'h0100, 32'h8, D2, 5'd4, 1));
    vecs.push_back(mk("srl", 32'h00022202, D1, D2, 5'd0, 5'd2, 0, 1, 16'h0200, 32'h8, D2, 5'd4, 1));
    vecs.push_back(mk("sra", 32'h03E117C3, D1, D2, 5'd31, 5'd1, 0, 1, 16'h0400, 32'h1F, D2, 5'd2, 1));
    vecs.push_back(mk("nop", 32'h00000000, D1, D2, 5'd0, 5'd0, 0, 1, 16'h0100, 32'h0, D2, 5'd0, 1));
`else
    vecs.push_back(mk("sll", 32'h00022200, D1, D2, 5'd0, 5'd2, 0, 0, 16'h0000, 32'h0, 32'h0, 5'd0, 0));
    vecs.push_back(mk("srl", 32'h00022202, D1, D2, 5'd0, 5'd2, 0, 0, 16'h0000, 32'h0, 32'h0, 5'd0, 0));
    vecs.push_back(mk("sra", 32'h03E117C3, D1, D2, 5'd31, 5'd1, 0, 0, 16'h0000, 32'h0, 32'h0, 5'd0, 0));
    vecs.push_back(mk("nop", 32'h00000000, D1, D2, 5'd0, 5'd0, 0, 0, 16'h0000, 32'h0, 32'h0, 5'd0, 0));
`endif
    vecs.push_back(mk("lui",   32'h3C05ABCD, D1, D2, 5'd0, 5'd5, 0, 0, 16'h0800, 32'h0, 32'hABCD0000, 5'd5, 1));
    vecs.push_back(mk("bad_op", 32'hFC000000, D1, D2, 5'd0, 5'd0, 0, 0, 16'h0000, 32'h0, 32'h0, 5'd0, 0));

    // reset state, held across edges with a live instruction present
    rst = 1'b1; inst_i = 32'h34011100; reg1_data_i = D1; reg2_data_i = D2;
    #1;
    chk_comb("reset", 5'd0, 5'd0, 0, 0);
    chk_regs("reset", 16'h0, 32'h0, 32'h0, 5'd0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_regs("reset_held", 16'h0, 32'h0, 32'h0, 5'd0, 0);

    @(negedge clk);
    rst = 1'b0;

    // table: drive at negedge, check comb side, then registered side after edge
    foreach (vecs[i]) begin
      if (i != 0) @(negedge clk);
      inst_i = vecs[i].inst; reg1_data_i = vecs[i].d1; reg2_data_i = vecs[i].d2;
      #1;
      chk_comb(vecs[i].name, vecs[i].a1, vecs[i].a2, vecs[i].rd1, vecs[i].rd2);
      @(posedge clk);
      #1;
      chk_regs(vecs[i].name, vecs[i].aluop, vecs[i].r1, vecs[i].r2, vecs[i].wd, vecs[i].wreg);
    end

    // async reset between edges with nonzero outputs
    @(negedge clk);
    inst_i = 32'h3C05ABCD; reg1_data_i = D1; reg2_data_i = D2;
    @(posedge clk);
    #1;
    chk_regs("lui_pre_rst", 16'h0800, 32'h0, 32'hABCD0000, 5'd5, 1);
    #1;
    rst = 1'b1;
    #1;
    chk_regs("async_rst", 16'h0, 32'h0, 32'h0, 5'd0, 0);
    chk_comb("async_rst", 5'd0, 5'd0, 0, 0);

    // in-flight decode during reset must not land
    @(negedge clk);
    inst_i = 32'h2422FFFF;
    @(posedge clk);
    #1;
    chk_regs("rst_discard", 16'h0, 32'h0, 32'h0, 5'd0, 0);

    // release: first edge captures the instruction present then
    @(negedge clk);
    rst = 1'b0;
    inst_i = 32'h00221825;
    #1;
    chk_comb("post_rst", 5'd1, 5'd2, 1, 1);
    @(posedge clk);
    #1;
    chk_regs("post_rst", 16'h0002, D1, D2, 5'd3, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
